// File: rtl/branch_stack_unit.sv
// Control-flow helper beside fetch: assembles branch targets, holds condition flags,
// resolves conditional branches and keeps a hardware call/return stack.
module branch_stack_unit #(
    parameter int unsigned ADDRESS_WIDTH = 15,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FLAG_COUNT    = 4,
    parameter int unsigned STACK_DEPTH   = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [2:0]                            act,
    input  logic [DATA_WIDTH-1:0]                 data,
    input  logic                                  reset_branch,
    input  logic [ADDRESS_WIDTH-1:0]              current_address,
    output logic                                  branch,
    output logic [ADDRESS_WIDTH-1:0]              branch_address,
    output logic [$clog2(STACK_DEPTH+1)-1:0]      stack_count,
    output logic                                  stack_overflow,
    output logic                                  stack_underflow,
    output logic                                  illegal_act
);

    localparam int unsigned FSW = $clog2(FLAG_COUNT);
    localparam int unsigned CW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PW  = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        ACT_NOP     = 3'd0,
        ACT_SHIFT   = 3'd1,
        ACT_SETFLAG = 3'd2,
        ACT_BRANCH  = 3'd3,
        ACT_CALL    = 3'd4,
        ACT_RETURN  = 3'd5,
        ACT_SAVE    = 3'd6,
        ACT_ILLEGAL = 3'd7
    } act_e;

    logic [FLAG_COUNT-1:0]            flags;
    logic [FLAG_COUNT-1:0]            flags_n;
    logic                             branch_n;
    logic [ADDRESS_WIDTH-1:0]         addr_n;
    logic [CW-1:0]                    count_n;
    logic                             overflow_n;
    logic                             underflow_n;
    logic                             illegal_n;
    logic                             push;
    logic [ADDRESS_WIDTH-1:0]         stack_mem [STACK_DEPTH];
    logic [FSW-1:0]                   fsel_set;
    logic [FSW-1:0]                   fsel_br;
    logic [1:0]                       op;
    logic [ADDRESS_WIDTH+DATA_WIDTH-1:0] shifted;
    logic                             stack_full;
    logic                             stack_empty;
    logic                             flag_hit;
    logic [PW-1:0]                    push_ptr;
    logic [PW-1:0]                    pop_ptr;

    assign fsel_set    = data[1 +: FSW];
    assign fsel_br     = data[2 +: FSW];
    assign op          = data[1:0];
    assign shifted     = {branch_address, data};
    assign stack_full  = (stack_count == CW'(STACK_DEPTH));
    assign stack_empty = (stack_count == '0);
    assign push_ptr    = PW'(stack_count);
    assign pop_ptr     = PW'(stack_count - CW'(1));
    // Out-of-range flag selects read as a cleared flag.
    assign flag_hit    = (32'(fsel_br) < FLAG_COUNT) && flags[fsel_br];

    // Next-state decode; a branch-setting command overrides reset_branch.
    always_comb begin
        branch_n    = branch;
        addr_n      = branch_address;
        flags_n     = flags;
        count_n     = stack_count;
        overflow_n  = stack_overflow;
        underflow_n = stack_underflow;
        illegal_n   = illegal_act;
        push        = 1'b0;

        if (reset_branch) begin
            branch_n = 1'b0;
        end

        case (act_e'(act))
            ACT_NOP: ;
            ACT_SHIFT: addr_n = shifted[ADDRESS_WIDTH-1:0];
            ACT_SETFLAG: begin
                if (32'(fsel_set) < FLAG_COUNT) begin
                    flags_n[fsel_set] = data[0];
                end else begin
                    illegal_n = 1'b1;
                end
            end
            ACT_BRANCH: begin
                case (op)
                    2'd0:    branch_n = 1'b1;
                    2'd1:    if (!flag_hit) branch_n = 1'b1;
                    2'd2:    if (flag_hit) branch_n = 1'b1;
                    default: illegal_n = 1'b1;
                endcase
            end
            ACT_CALL: begin
                if (!stack_full) begin
                    push     = 1'b1;
                    count_n  = stack_count + CW'(1);
                    branch_n = 1'b1;
                end else begin
                    overflow_n = 1'b1;
                end
            end
            ACT_RETURN: begin
                if (!stack_empty) begin
                    addr_n   = stack_mem[pop_ptr];
                    count_n  = stack_count - CW'(1);
                    branch_n = 1'b1;
                end else begin
                    underflow_n = 1'b1;
                end
            end
            ACT_SAVE:    addr_n = current_address;
            ACT_ILLEGAL: illegal_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            branch          <= 1'b0;
            branch_address  <= '0;
            flags           <= '0;
            stack_count     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            illegal_act     <= 1'b0;
        end else begin
            branch          <= branch_n;
            branch_address  <= addr_n;
            flags           <= flags_n;
            stack_count     <= count_n;
            stack_overflow  <= overflow_n;
            stack_underflow <= underflow_n;
            illegal_act     <= illegal_n;
        end
    end

    // Entry storage survives reset; only the occupancy count is cleared.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            stack_mem[push_ptr] <= current_address;
        end
    end

endmodule

// File: tb/tb_branch_stack_unit.sv
// Randomised and directed bench for branch_stack_unit against a queue-based reference model.
module tb_branch_stack_unit;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int FC = 4;
    localparam int SD = 8;

    logic          clock;
    logic          reset;
    logic [2:0]    act;
    logic [DW-1:0] data;
    logic          reset_branch;
    logic [AW-1:0] current_address;
    logic          branch;
    logic [AW-1:0] branch_address;
    logic [3:0]    stack_count;
    logic          stack_overflow;
    logic          stack_underflow;
    logic          illegal_act;

    int checks = 0;
    int passed = 0;

    // Reference model state
    bit          m_branch;
    int unsigned m_addr;
    int          m_flags [FC];
    int unsigned m_stack [$];
    bit          m_ovf, m_unf, m_ill;

    branch_stack_unit #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FLAG_COUNT(FC), .STACK_DEPTH(SD)
    ) dut (
        .clock(clock), .reset(reset), .act(act), .data(data),
        .reset_branch(reset_branch), .current_address(current_address),
        .branch(branch), .branch_address(branch_address), .stack_count(stack_count),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow),
        .illegal_act(illegal_act)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_apply(input int a, input int unsigned d, input bit rb,
                               input int unsigned cur, input bit rst);
        int sel;
        int op;
        if (rst) begin
            m_branch = 0; m_addr = 0; m_ovf = 0; m_unf = 0; m_ill = 0;
            foreach (m_flags[i]) m_flags[i] = 0;
            m_stack.delete();
            return;
        end
        if (rb) m_branch = 0;
        case (a)
            1: m_addr = (m_addr * (1 << DW) + d) % (1 << AW);
            2: begin
                sel = (d >> 1) % FC;
                m_flags[sel] = d % 2;
            end
            3: begin
                op  = d % 4;
                sel = (d >> 2) % FC;
                if (op == 0) m_branch = 1;
                else if (op == 1 && m_flags[sel] == 0) m_branch = 1;
                else if (op == 2 && m_flags[sel] != 0) m_branch = 1;
                else if (op == 3) m_ill = 1;
            end
            4: begin
                if (m_stack.size() < SD) begin
                    m_stack.push_back(cur);
                    m_branch = 1;
                end else m_ovf = 1;
            end
            5: begin
                if (m_stack.size() > 0) begin
                    m_addr = m_stack.pop_back();
                    m_branch = 1;
                end else m_unf = 1;
            end
            6: m_addr = cur;
            7: m_ill = 1;
            default: ;
        endcase
    endtask

    // One clock: drive inputs, advance the model at the edge, settle before sampling.
    task automatic cyc(input int a, input int unsigned d, input bit rb,
                       input int unsigned cur, input bit rst);
        act = 3'(a); data = DW'(d); reset_branch = rb; current_address = AW'(cur); reset = rst;
        @(posedge clock);
        model_apply(a, d, rb, cur, rst);
        #1;
        act = '0; reset_branch = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        checks++; if (branch !== 1'b0) $display("FAIL reset_branch got %0b exp 0", branch); else passed++;
        checks++; if (branch_address !== '0) $display("FAIL reset_addr got %0h exp 0", branch_address); else passed++;
        checks++; if (stack_count !== '0) $display("FAIL reset_count got %0d exp 0", stack_count); else passed++;
        checks++; if ({stack_overflow, stack_underflow, illegal_act} !== 3'b000)
            $display("FAIL reset_errors got %b exp 000", {stack_overflow, stack_underflow, illegal_act}); else passed++;
    endtask

    task automatic test_shift;
        cyc(1, 'h12, 0, 0, 0);
        cyc(1, 'h34, 0, 0, 0);
        checks++; if (branch_address !== 15'h1234) $display("FAIL shift_addr got %0h exp 1234", branch_address); else passed++;
        checks++; if (branch !== 1'b0) $display("FAIL shift_branch got %0b exp 0", branch); else passed++;
        cyc(1, 'hAB, 0, 0, 0);
        checks++; if (branch_address !== 15'h34AB) $display("FAIL shift_trunc got %0h exp 34ab", branch_address); else passed++;
    endtask

    task automatic test_flag_branch;
        cyc(2, 'h03, 0, 0, 0);
        cyc(3, 'h06, 0, 0, 0);
        checks++; if (branch !== 1'b1) $display("FAIL br_op2_taken got %0b exp 1", branch); else passed++;
        cyc(0, 0, 1, 0, 0);
        checks++; if (branch !== 1'b0) $display("FAIL br_ack got %0b exp 0", branch); else passed++;
        cyc(3, 'h05, 0, 0, 0);
        checks++; if (branch !== 1'b0) $display("FAIL br_op1_not_taken got %0b exp 0", branch); else passed++;
        cyc(3, 'h01, 0, 0, 0);
        checks++; if (branch !== 1'b1) $display("FAIL br_op1_flag0 got %0b exp 1", branch); else passed++;
        cyc(0, 0, 1, 0, 0);
        checks++; if (illegal_act !== 1'b0) $display("FAIL br_no_illegal got %0b exp 0", illegal_act); else passed++;
    endtask

    task automatic test_call_return;
        int unsigned exp_addr [3] = '{'h300, 'h200, 'h100};
        cyc(4, 0, 0, 'h100, 0);
        cyc(4, 0, 0, 'h200, 0);
        cyc(4, 0, 0, 'h300, 0);
        checks++; if (stack_count !== 4'd3) $display("FAIL call_count got %0d exp 3", stack_count); else passed++;
        for (int i = 0; i < 3; i++) begin
            cyc(5, 0, 1, 0, 0);
            checks++;
            if (branch_address !== AW'(exp_addr[i]) || branch !== 1'b1)
                $display("FAIL ret_%0d got addr=%0h br=%0b exp addr=%0h br=1", i, branch_address, branch, exp_addr[i]);
            else passed++;
        end
        checks++; if (stack_count !== 4'd0) $display("FAIL ret_count got %0d exp 0", stack_count); else passed++;
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 8; i++) cyc(4, 0, 0, 'h40 + i, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(4, 0, 0, 'h7777, 0);
        checks++; if (stack_count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", stack_count); else passed++;
        checks++; if (stack_overflow !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", stack_overflow); else passed++;
        checks++; if (branch !== 1'b0) $display("FAIL ovf_branch got %0b exp 0", branch); else passed++;
        for (int i = 0; i < 8; i++) cyc(5, 0, 0, 0, 0);
        checks++; if (branch_address !== 15'h40) $display("FAIL ovf_bottom got %0h exp 40", branch_address); else passed++;
        cyc(5, 0, 1, 0, 0);
        checks++; if (stack_underflow !== 1'b1) $display("FAIL unf_flag got %0b exp 1", stack_underflow); else passed++;
        checks++; if (branch_address !== 15'h40 || branch !== 1'b0)
            $display("FAIL unf_state got addr=%0h br=%0b exp addr=40 br=0", branch_address, branch); else passed++;
    endtask

    task automatic test_back_to_back;
        cyc(3, 'h00, 1, 0, 0);
        checks++; if (branch !== 1'b1) $display("FAIL cmd_over_ack got %0b exp 1", branch); else passed++;
        cyc(7, 0, 0, 0, 0);
        checks++; if (illegal_act !== 1'b1) $display("FAIL act7_illegal got %0b exp 1", illegal_act); else passed++;
        cyc(6, 0, 0, 'h5A5A, 0);
        checks++; if (branch_address !== 15'h5A5A) $display("FAIL save_after_err got %0h exp 5a5a", branch_address); else passed++;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) cyc(4, 0, 0, 'h10 * i, 0);
        checks++; if (stack_count !== 4'd5) $display("FAIL mid_count got %0d exp 5", stack_count); else passed++;
        cyc(4, 0, 0, 'h1FF, 1);
        checks++;
        if ({branch, branch_address, stack_count, stack_overflow, stack_underflow, illegal_act} !== '0)
            $display("FAIL mid_reset got br=%0b addr=%0h cnt=%0d err=%b exp all 0", branch, branch_address,
                     stack_count, {stack_overflow, stack_underflow, illegal_act});
        else passed++;
        cyc(5, 0, 0, 0, 0);
        checks++; if (stack_underflow !== 1'b1) $display("FAIL mid_underflow got %0b exp 1", stack_underflow); else passed++;
    endtask

    task automatic test_random;
        int a;
        bit rst;
        for (int n = 0; n < 600; n++) begin
            a   = $urandom_range(0, 7);
            rst = ($urandom_range(0, 39) == 0);
            cyc(a, $urandom_range(0, 255), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 32767), rst);
            checks++; if (branch !== m_branch) $display("FAIL rnd_branch n=%0d got %0b exp %0b", n, branch, m_branch); else passed++;
            checks++; if (branch_address !== AW'(m_addr)) $display("FAIL rnd_addr n=%0d got %0h exp %0h", n, branch_address, m_addr); else passed++;
            checks++; if (stack_count !== 4'(m_stack.size())) $display("FAIL rnd_count n=%0d got %0d exp %0d", n, stack_count, m_stack.size()); else passed++;
            checks++; if ({stack_overflow, stack_underflow, illegal_act} !== {m_ovf, m_unf, m_ill})
                $display("FAIL rnd_errors n=%0d got %b exp %b", n, {stack_overflow, stack_underflow, illegal_act}, {m_ovf, m_unf, m_ill});
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; act = '0; data = '0; reset_branch = 1'b0; current_address = '0;
        test_reset();
        test_shift();
        test_flag_branch();
        test_call_return();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        cyc(0, 0, 0, 0, 1);
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
